// File: rtl/lsq_mshr_q_if.sv
// Bus bundle for the load/store MSHR queue.
// The master side is the cache pipeline and consumer. It enqueues entries,
// broadcasts MSHR completions and accepts the head entry.
// The slave side is the queue itself.
interface lsq_mshr_q_if #(
    parameter int OOO_TAG_BITS  = 6,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int OP_BITS       = 3,
    parameter int MSHR_IDX_BITS = 3,
    parameter int CNT_W         = 4
) ();
    logic                     stall;
    logic                     flush;
    logic                     wr;
    logic [OP_BITS-1:0]       operation_in;
    logic [ADDR_WIDTH-1:0]    addr_in;
    logic [DATA_WIDTH-1:0]    data_in;
    logic [OOO_TAG_BITS-1:0]  ooo_tag_in;
    logic                     mshr_wait_in;
    logic [MSHR_IDX_BITS-1:0] mshr_wr_idx;
    logic                     mshr_fin;
    logic [MSHR_IDX_BITS-1:0] mshr_fin_idx;
    logic                     out_ready;
    logic                     valid_out;
    logic [OP_BITS-1:0]       operation_out;
    logic [ADDR_WIDTH-1:0]    addr_out;
    logic [DATA_WIDTH-1:0]    data_out;
    logic [OOO_TAG_BITS-1:0]  ooo_tag_out;
    logic                     lsq_full;
    logic                     lsq_empty;
    logic [CNT_W-1:0]         count;

    modport master (
        output stall, flush, wr, operation_in, addr_in, data_in, ooo_tag_in,
               mshr_wait_in, mshr_wr_idx, mshr_fin, mshr_fin_idx, out_ready,
        input  valid_out, operation_out, addr_out, data_out, ooo_tag_out,
               lsq_full, lsq_empty, count
    );

    modport slave (
        input  stall, flush, wr, operation_in, addr_in, data_in, ooo_tag_in,
               mshr_wait_in, mshr_wr_idx, mshr_fin, mshr_fin_idx, out_ready,
        output valid_out, operation_out, addr_out, data_out, ooo_tag_out,
               lsq_full, lsq_empty, count
    );
endinterface

// File: rtl/lsq_mshr_q.sv
// In-order load/store queue with MSHR wake-up.
// Entries that wait on an MSHR become ready when the matching completion is
// broadcast. The head entry issues only when it is ready, so a waiting head
// blocks every younger entry.
module lsq_mshr_q #(
    parameter int Q_LENGTH      = 8,
    parameter int OOO_TAG_BITS  = 6,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int OP_BITS       = 3,
    parameter int MSHR_IDX_BITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    lsq_mshr_q_if.slave   bus
);
    localparam int PTR_W = $clog2(Q_LENGTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [Q_LENGTH-1:0]      valid_q, valid_d, rdy_q, rdy_d, wake;
    logic [MSHR_IDX_BITS-1:0] midx_q [Q_LENGTH];
    logic [MSHR_IDX_BITS-1:0] midx_d [Q_LENGTH];
    logic [OP_BITS-1:0]       op_q   [Q_LENGTH];
    logic [OP_BITS-1:0]       op_d   [Q_LENGTH];
    logic [ADDR_WIDTH-1:0]    addr_q [Q_LENGTH];
    logic [ADDR_WIDTH-1:0]    addr_d [Q_LENGTH];
    logic [DATA_WIDTH-1:0]    data_q [Q_LENGTH];
    logic [DATA_WIDTH-1:0]    data_d [Q_LENGTH];
    logic [OOO_TAG_BITS-1:0]  tag_q  [Q_LENGTH];
    logic [OOO_TAG_BITS-1:0]  tag_d  [Q_LENGTH];

    logic full, empty, head_valid, head_rdy, issue_ok, enq_fire, deq_fire, enq_rdy;

    assign full       = (count_q == CNT_W'(Q_LENGTH));
    assign empty      = (count_q == '0);
    assign head_valid = valid_q[head_q];
    assign head_rdy   = rdy_q[head_q];
    assign issue_ok   = head_valid && head_rdy;
    assign enq_fire   = bus.wr && !full && !bus.flush;
    assign deq_fire   = issue_ok && bus.out_ready && !bus.stall && !bus.flush;
    // A completion for the same MSHR in the enqueue cycle counts as already done.
    assign enq_rdy    = !bus.mshr_wait_in ||
                        (bus.mshr_fin && (bus.mshr_fin_idx == bus.mshr_wr_idx));

    // Each waiting entry listens to the completion broadcast independently.
    genvar gi;
    generate
        for (gi = 0; gi < Q_LENGTH; gi++) begin : g_wake
            assign wake[gi] = bus.mshr_fin && valid_q[gi] && !rdy_q[gi] &&
                              (midx_q[gi] == bus.mshr_fin_idx);
        end
    endgenerate

    // Next-state: wake, dequeue, enqueue, count. Flush overrides all of them.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        rdy_d   = rdy_q | wake;
        midx_d  = midx_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tag_d   = tag_q;

        if (deq_fire) begin
            valid_d[head_q] = 1'b0;
            rdy_d[head_q]   = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        // Enqueue only happens when not full, so the tail slot is free.
        // Dequeue frees the head slot, which is a different slot.
        if (enq_fire) begin
            valid_d[tail_q] = 1'b1;
            rdy_d[tail_q]   = enq_rdy;
            midx_d[tail_q]  = bus.mshr_wr_idx;
            op_d[tail_q]    = bus.operation_in;
            addr_d[tail_q]  = bus.addr_in;
            data_d[tail_q]  = bus.data_in;
            tag_d[tail_q]   = bus.ooo_tag_in;
            tail_d          = tail_q + PTR_W'(1);
        end

        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.flush) begin
            valid_d = '0;
            rdy_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // State registers; reset empties the queue and zeroes the payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            rdy_q   <= '0;
            for (int i = 0; i < Q_LENGTH; i++) begin
                midx_q[i] <= '0;
                op_q[i]   <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
            midx_q  <= midx_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    // The head drives the outputs. Payload reads as zero when the head slot is empty.
    assign bus.valid_out     = issue_ok;
    assign bus.operation_out = head_valid ? op_q[head_q]   : '0;
    assign bus.addr_out      = head_valid ? addr_q[head_q] : '0;
    assign bus.data_out      = head_valid ? data_q[head_q] : '0;
    assign bus.ooo_tag_out   = head_valid ? tag_q[head_q]  : '0;
    assign bus.lsq_full      = full;
    assign bus.lsq_empty     = empty;
    assign bus.count         = count_q;
endmodule

// File: tb/tb_lsq_mshr_q.sv
// Bench for lsq_mshr_q.
// Directed scenarios run first, then a randomized phase. The outputs are
// compared every cycle against a queue-based reference model.
module tb_lsq_mshr_q;
    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsq_mshr_q_if #(.OOO_TAG_BITS(6), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                    .OP_BITS(3), .MSHR_IDX_BITS(3), .CNT_W(4)) bus ();

    lsq_mshr_q #(.Q_LENGTH(Q), .OOO_TAG_BITS(6), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                 .OP_BITS(3), .MSHR_IDX_BITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [5:0]  tag;
        bit          pend;
        logic [2:0]  midx;
    } ent_t;

    ent_t mq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the queue advances one clock edge using the inputs present at that edge.
    task automatic model_update();
        bit   mv, do_deq, do_enq;
        ent_t e;
        if (rst || bus.flush) begin
            mq.delete();
            return;
        end
        mv     = (mq.size() > 0) && !mq[0].pend;
        do_deq = mv && bus.out_ready && !bus.stall;
        do_enq = bus.wr && (mq.size() < Q);
        if (bus.mshr_fin) begin
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (e.pend && e.midx == bus.mshr_fin_idx) begin
                    e.pend = 1'b0;
                    mq[i]  = e;
                end
            end
        end
        if (do_deq) begin
            $display("deq tag=%0d addr=%0h data=%0h op=%0d", mq[0].tag, mq[0].addr, mq[0].data, mq[0].op);
            void'(mq.pop_front());
        end
        if (do_enq) begin
            e.op   = bus.operation_in;
            e.addr = bus.addr_in;
            e.data = bus.data_in;
            e.tag  = bus.ooo_tag_in;
            e.midx = bus.mshr_wr_idx;
            e.pend = bus.mshr_wait_in &&
                     !(bus.mshr_fin && bus.mshr_fin_idx == bus.mshr_wr_idx);
            mq.push_back(e);
        end
    endtask

    task automatic check_all();
        bit   hv;
        ent_t h;
        hv = mq.size() > 0;
        if (hv) h = mq[0];
        chk("valid_out", bus.valid_out, hv && !h.pend);
        chk("count", bus.count, mq.size());
        chk("lsq_full", bus.lsq_full, mq.size() == Q);
        chk("lsq_empty", bus.lsq_empty, mq.size() == 0);
        chk("operation_out", bus.operation_out, hv ? h.op : 3'd0);
        chk("addr_out", bus.addr_out, hv ? h.addr : 32'd0);
        chk("data_out", bus.data_out, hv ? h.data : 32'd0);
        chk("ooo_tag_out", bus.ooo_tag_out, hv ? h.tag : 6'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle();
        bus.stall = 0; bus.flush = 0; bus.wr = 0; bus.operation_in = 0;
        bus.addr_in = 0; bus.data_in = 0; bus.ooo_tag_in = 0;
        bus.mshr_wait_in = 0; bus.mshr_wr_idx = 0; bus.mshr_fin = 0;
        bus.mshr_fin_idx = 0; bus.out_ready = 0;
    endtask

    task automatic set_enq(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                           input logic [5:0] t, input bit w, input logic [2:0] idx);
        bus.wr = 1; bus.operation_in = op; bus.addr_in = a; bus.data_in = d;
        bus.ooo_tag_in = t; bus.mshr_wait_in = w; bus.mshr_wr_idx = idx;
    endtask

    initial begin
        idle();
        // Reset state is checked while rst is still held high.
        step(); step();
        rst = 0;
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.lsq_empty, 1);

        // Single ready entry: visible one cycle after wr, then dequeued.
        set_enq(3'b010, 32'h1000, 32'hDEADBEEF, 6'd5, 0, 0);
        step();
        idle();
        chk("t1_valid", bus.valid_out, 1);
        chk("t1_tag", bus.ooo_tag_out, 5);
        chk("t1_data", bus.data_out, 32'hDEADBEEF);
        bus.out_ready = 1;
        step();
        chk("t1_empty", bus.lsq_empty, 1);

        // Fill to full. The 9th write is dropped. Then drain, and refill across the wrap.
        idle();
        for (int i = 0; i < 9; i++) begin
            set_enq(3'(i), 32'h2000 + 32'(i * 4), 32'(i * 7), 6'(10 + i), 0, 0);
            step();
        end
        idle();
        chk("t2_full", bus.lsq_full, 1);
        chk("t2_count", bus.count, 8);
        bus.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_order", bus.ooo_tag_out, 6'(10 + i));
            step();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            set_enq(3'd1, 32'h3000 + 32'(i), 32'(i), 6'(30 + i), 0, 0);
            step();
        end
        idle();
        bus.out_ready = 1;
        repeat (4) step();

        // A waiting head blocks a younger ready entry until its own MSHR completes.
        idle();
        set_enq(3'd4, 32'hA0, 32'hA, 6'd20, 1, 3'd2); step();
        set_enq(3'd5, 32'hB0, 32'hB, 6'd21, 0, 3'd0); step();
        idle(); step();
        chk("t3_blocked", bus.valid_out, 0);
        bus.mshr_fin = 1; bus.mshr_fin_idx = 3'd1; step();
        chk("t3_wrong_idx", bus.valid_out, 0);
        bus.mshr_fin_idx = 3'd2; step();
        idle();
        chk("t3_woken_A", bus.ooo_tag_out, 20);
        bus.out_ready = 1; step();
        chk("t3_then_B", bus.ooo_tag_out, 21);
        step();

        // A completion in the same cycle as the enqueue makes the new entry ready.
        idle();
        set_enq(3'd6, 32'hC0, 32'hC, 6'd40, 1, 3'd4);
        bus.mshr_fin = 1; bus.mshr_fin_idx = 3'd4;
        step();
        idle();
        chk("t4_same_cycle", bus.valid_out, 1);
        bus.out_ready = 1; step();

        // One broadcast wakes three entries. Stall then holds them in place.
        idle();
        for (int i = 0; i < 3; i++) begin
            set_enq(3'd7, 32'hD0 + 32'(i), 32'(i), 6'(50 + i), 1, 3'd6);
            step();
        end
        idle(); bus.mshr_fin = 1; bus.mshr_fin_idx = 3'd6; step();
        idle(); bus.stall = 1; bus.out_ready = 1; step();
        chk("t5_stall_count", bus.count, 3);
        bus.stall = 0;
        repeat (3) step();

        // Flush with a concurrent write leaves the queue empty.
        idle();
        for (int i = 0; i < 4; i++) begin
            set_enq(3'd2, 32'hE0 + 32'(i), 32'(i), 6'(60 + i), 0, 0);
            step();
        end
        set_enq(3'd2, 32'hEF, 32'hF, 6'd63, 0, 0);
        bus.flush = 1; step();
        idle();
        chk("t6_flush_count", bus.count, 0);

        // Reset in the middle of a drain clears the outputs immediately.
        for (int i = 0; i < 3; i++) begin
            set_enq(3'd3, 32'hF0 + 32'(i), 32'(i), 6'(1 + i), 0, 0);
            step();
        end
        idle(); bus.out_ready = 1; step();
        rst = 1;
        #1;
        mq.delete();
        check_all();
        step();
        rst = 0;

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            bus.wr           = ($urandom_range(0, 99) < 55);
            bus.operation_in = 3'($urandom);
            bus.addr_in      = $urandom;
            bus.data_in      = $urandom;
            bus.ooo_tag_in   = 6'($urandom);
            bus.mshr_wait_in = ($urandom_range(0, 99) < 40);
            bus.mshr_wr_idx  = 3'($urandom_range(0, 3));
            bus.mshr_fin     = ($urandom_range(0, 99) < 30);
            bus.mshr_fin_idx = 3'($urandom_range(0, 3));
            bus.stall        = ($urandom_range(0, 99) < 20);
            bus.out_ready    = ($urandom_range(0, 99) < 60);
            bus.flush        = ($urandom_range(0, 99) < 2);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lsq_mshr_q.md
Name: lsq_mshr_q

Overview:
- Parametrised in-order load/store queue that sits between the cache pipeline and the memory-side issue logic.
- Each entry either waits on an outstanding MSHR or is ready at enqueue.
- A broadcast MSHR-fill completion wakes every waiting entry whose index matches.
- The head entry issues through a valid/ready handshake with stall. Adds depth, width and MSHR-count generalisation, occupancy count, flush, and same-cycle wake-on-enqueue.

Parameters:
Q_LENGTH, 8, queue depth; power of two, >= 2
OOO_TAG_BITS, 6, width of out-of-order tag
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, store-data width
OP_BITS, 3, operation code width
MSHR_IDX_BITS, 3, MSHR index width (2**MSHR_IDX_BITS MSHRs)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  blocks dequeue this cycle
flush  in  1  synchronous clear of all entries
wr  in  1  enqueue request
operation_in  in  OP_BITS  operation of new entry
addr_in  in  ADDR_WIDTH  address of new entry
data_in  in  DATA_WIDTH  data of new entry
ooo_tag_in  in  OOO_TAG_BITS  tag of new entry
mshr_wait_in  in  1  1 = new entry waits on MSHR mshr_wr_idx
mshr_wr_idx  in  MSHR_IDX_BITS  MSHR the new entry depends on
mshr_fin  in  1  MSHR completion broadcast valid
mshr_fin_idx  in  MSHR_IDX_BITS  index of completing MSHR
out_ready  in  1  consumer accepts head
valid_out  out  1  head present and ready
operation_out  out  OP_BITS  head operation
addr_out  out  ADDR_WIDTH  head address
data_out  out  DATA_WIDTH  head data
ooo_tag_out  out  OOO_TAG_BITS  head tag
lsq_full  out  1  count == Q_LENGTH
lsq_empty  out  1  count == 0
count  out  $clog2(Q_LENGTH)+1  occupancy

Behaviour:
- Storage: circular buffer, head/tail pointers $clog2(Q_LENGTH) bits wrapping modulo Q_LENGTH, plus separate count register.
- Per entry: payload, valid, rdy, midx.
- Reset (async, rst=1): all valid/rdy/payload = 0, head = tail = count = 0.
  - Outputs: valid_out=0, lsq_empty=1, lsq_full=0, count=0, payload outputs 0.
- Enqueue accepted iff wr && !lsq_full && !flush.
  - Writes entry at tail, valid=1, midx=mshr_wr_idx.
  - rdy = !mshr_wait_in || (mshr_fin && mshr_fin_idx==mshr_wr_idx): same-cycle completion must not be missed.
  - tail++.
  - wr while full is dropped; no state change.
  - No enqueue-while-full even with a simultaneous dequeue.
- Wake: when mshr_fin=1, every valid entry with rdy=0 and midx==mshr_fin_idx sets rdy=1 at the clock edge. Zero, one or many entries may wake per cycle.
- Output (combinational from head entry):
  - valid_out = head.valid && head.rdy.
  - Payload outputs = head payload when head.valid, else 0.
  - Non-ready head blocks younger ready entries (strict in-order).
- Dequeue fires iff valid_out && out_ready && !stall && !flush. Clears head valid/rdy; head++.
- count: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither.
- Simultaneous enqueue + dequeue at count==Q_LENGTH-1 or 1: both succeed, count unchanged.
- flush (sync): clears all valid/rdy, head=tail=count=0. Overrides wr, dequeue and wake in the same cycle.
- Latency:
  - An entry enqueued ready into an empty queue gives valid_out=1 the cycle after wr.
  - A woken entry at head gives valid_out=1 the cycle after mshr_fin.
- Reset asserted mid-operation discards all entries immediately. Outputs are at reset values while rst=1.

Test Plan:
- Reset, then wr ready entry (op=3'b010, addr=0x1000, data=0xDEADBEEF, tag=5) -> next cycle valid_out=1 with those values, count=1. out_ready=1 -> following cycle lsq_empty=1, count=0.
- Enqueue 8 entries with mshr_wait_in=0, then a 9th wr -> lsq_full=1, 9th dropped, count=8. Drain 8 -> tags emerge in enqueue order; pointers wrap on refill of 3 more.
- Enqueue A (wait, idx 2) then B (ready) -> valid_out=0 (head blocked). mshr_fin idx 1 -> still 0. mshr_fin idx 2 -> next cycle valid_out=1 with A, then B after A dequeues.
- wr with mshr_wait_in=1, mshr_wr_idx=4, same cycle mshr_fin=1, fin_idx=4 -> entry ready, valid_out=1 next cycle.
- Three entries waiting on idx 6 -> one mshr_fin idx 6 wakes all. With stall=1 and out_ready=1, no dequeue and count stays 3. stall=0 -> drains one per cycle.
- count=4 and flush=1 with wr=1 -> next cycle count=0, lsq_empty=1, valid_out=0. rst pulsed mid-drain -> outputs at reset values immediately.
